// File: rtl/uart_rx_pkg.sv
// UART RX controller shared types: FSM state encoding and the
// oversampling ratios the controller accepts.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [5:0] PS_8  = 6'd8;
    localparam logic [5:0] PS_16 = 6'd16;
    localparam logic [5:0] PS_32 = 6'd32;

    function automatic logic legal_ps(input logic [5:0] ps);
        return (ps == PS_8) || (ps == PS_16) || (ps == PS_32);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_edge_bit_counter.sv
// Oversample edge counter and frame bit counter for the UART RX path.
// Ports: clk, rst (sync, active-high), enable (count, else clear),
//        ps_q (latched prescale); edge_cnt, bit_cnt, bit_end.
module edge_bit_counter
    import uart_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [5:0] ps_q,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       bit_end
);

    assign bit_end = (edge_cnt == (ps_q - 6'd1));

    // Dropping enable clears both counters, so the first cycle of a
    // new frame always starts at edge 0 of bit 0.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (bit_end) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 6'd1;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX sequencer: start detect, START/DATA/PARITY/STOP stepping,
// checker/sampler/deserializer enables and frame result pulses.
// Ports: clk, rst (sync, active-high), RX_IN, PAR_EN, PRESCALE,
//        strt_glitch, par_err, stp_err in; edge_cnt, bit_cnt,
//        dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
//        data_valid, rx_err, busy out.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int width = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] PRESCALE,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       rx_err,
    output logic       busy
);

    localparam logic [3:0] LAST_DATA = 4'(width);

    state_t     state;
    state_t     state_next;
    logic       rx_prev;
    logic       armed;
    logic [5:0] ps_q;
    logic       par_q;
    logic       err_q;
    logic       bit_end;
    logic       cnt_en;
    logic       start_det;
    logic       frame_bad;
    logic       dv_set;
    logic       err_set;

    // armed stays low after reset until the line is seen high, so a
    // line held low across reset cannot look like a fresh start bit.
    assign start_det = armed && rx_prev && !RX_IN;

    // Counters run while busy and clear in the cycle that leaves for
    // IDLE, so they read 0 in IDLE and in the first START cycle.
    assign cnt_en = (state != IDLE) && (state_next != IDLE);

    edge_bit_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .enable   (cnt_en),
        .ps_q     (ps_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_end  (bit_end)
    );

    assign busy        = (state != IDLE);
    assign dat_samp_en = (state != IDLE);

    always_comb begin
        state_next  = state;
        deser_en    = 1'b0;
        strt_chk_en = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_det) state_next = START;
            end
            START: begin
                strt_chk_en = 1'b1;
                if (bit_end) state_next = strt_glitch ? IDLE : DATA;
            end
            DATA: begin
                deser_en = 1'b1;
                if (bit_end && bit_cnt == LAST_DATA)
                    state_next = par_q ? PARITY : STOP;
            end
            PARITY: begin
                par_chk_en = 1'b1;
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                stp_chk_en = 1'b1;
                if (bit_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Result pulses are registered so they land in the first IDLE
    // cycle, after the deserializer has taken its last shift.
    assign frame_bad = err_q | stp_err;
    assign dv_set    = (state == STOP) && bit_end && !frame_bad;
    assign err_set   = ((state == START) && bit_end && strt_glitch) ||
                       ((state == STOP) && bit_end && frame_bad);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rx_prev    <= 1'b1;
            armed      <= 1'b0;
            ps_q       <= PS_8;
            par_q      <= 1'b0;
            err_q      <= 1'b0;
            data_valid <= 1'b0;
            rx_err     <= 1'b0;
        end else begin
            state      <= state_next;
            rx_prev    <= RX_IN;
            data_valid <= dv_set;
            rx_err     <= err_set;
            if (RX_IN) armed <= 1'b1;
            if (state == IDLE && start_det) begin
                ps_q  <= PRESCALE;
                par_q <= PAR_EN;
                err_q <= 1'b0;
            end else if (state == PARITY && bit_end) begin
                err_q <= par_err;
            end
        end
    end

    a_ps_legal : assert property (
        @(posedge clk) disable iff (rst)
        (state == IDLE && start_det) |-> legal_ps(PRESCALE)
    );

endmodule
